// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b - bin, one bit per cycle LSB first through a single cell.
// Latency: WIDTH cycles from accept to done_valid.
// Backpressure: result held in DONE until done_ready; start_ready is high only in IDLE.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin_in,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             done_valid,
    input  logic             done_ready
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic             cell_a;
    logic             cell_b;
    logic             sub;
    logic             bor;

    // Single full-subtractor cell shared across all bit positions.
    always_comb begin
        cell_a = a_sr[0];
        cell_b = b_sr[0];
        sub    = cell_a ^ cell_b ^ borrow;
        bor    = (~cell_a & cell_b) | (~(cell_a ^ cell_b) & borrow);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            done_valid  <= 1'b0;
            diff        <= '0;
            bout        <= 1'b0;
            a_sr        <= '0;
            b_sr        <= '0;
            r_sr        <= '0;
            borrow      <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_sr        <= a_in;
                        b_sr        <= b_in;
                        borrow      <= bin_in;
                        cnt         <= '0;
                        start_ready <= 1'b0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    r_sr   <= {sub, r_sr[WIDTH-1:1]};
                    borrow <= bor;
                    // Publish on the final bit so diff/bout stay frozen while the shifters run.
                    if (cnt == LAST) begin
                        diff       <= {sub, r_sr[WIDTH-1:1]};
                        bout       <= bor;
                        done_valid <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        done_valid  <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    start_ready <= 1'b1;
                    done_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor computing diff = a - b - bin over WIDTH clock cycles, one bit per cycle, LSB first. It sits directly upstream of the single-bit full-subtractor cell and feeds it: it sequences operand bits and the registered borrow into the cell, then collects the cell's difference and borrow outputs. It trades WIDTH cycles of latency for a single subtractor cell. Operands and results use a valid/ready handshake.

## Interface
- WIDTH, 8: operand and result width in bits; legal range 2..32.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start_valid  input  1  operands on a_in/b_in/bin_in are valid.
- start_ready  output  1  block can accept operands; high only in IDLE.
- a_in  input  WIDTH  minuend, unsigned.
- b_in  input  WIDTH  subtrahend, unsigned.
- bin_in  input  1  borrow-in.
- diff  output  WIDTH  result, (a - b - bin) mod 2^WIDTH.
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).
- done_valid  output  1  diff/bout hold a completed result.
- done_ready  input  1  consumer accepts the result.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: start_ready=1. On start_valid=1 at a clock edge, the block loads a_in into shift register A, b_in into shift register B, and bin_in into the borrow flop. It clears the bit counter and moves to BUSY.
- BUSY: each cycle the cell computes on bit a=A[0], b=B[0], bin=borrow.
  - sub = a ^ b ^ bin.
  - bor = (~a & b) | (~(a ^ b) & bin).
  - The register updates A >>= 1 and B >>= 1.
  - sub shifts into the result register from the MSB side: R = {sub, R[WIDTH-1:1]}.
  - borrow <= bor and the counter increments.
  - When the counter equals WIDTH-1 at the edge, the state moves to DONE.
- Counter width: $clog2(WIDTH). It never wraps, because it stops at WIDTH-1.
- DONE: done_valid=1. diff=R and bout=borrow are held stable. On done_ready=1 at an edge, the state moves to IDLE.
- start_valid is ignored outside IDLE. Operands presented in BUSY or DONE are not captured.
- No same-cycle restart: DONE to IDLE costs one cycle before the next accept.
- done_ready is ignored outside DONE.
- diff and bout keep their last value in IDLE and BUSY. They are only qualified by done_valid.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, start_ready=1, done_valid=0, diff=0, bout=0, counter=0, A=B=0.
- A reset during BUSY or DONE aborts the operation immediately and discards the result. The first accept after reset release starts a fresh operation.
- Accept at edge N (IDLE, start_valid=1) leads to BUSY from N through N+WIDTH-1 and done_valid=1 after edge N+WIDTH. Latency is WIDTH cycles.
- start_ready falls after edge N and returns high after the edge where DONE is exited with done_ready=1.
- Minimum issue interval is WIDTH+2 cycles, with done_ready tied high.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- WIDTH=8, a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0. done_valid rises exactly 8 cycles after accept.
- WIDTH=8, a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1. Also a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1. Also a=0xFF, b=0xFF, bin=0 -> diff=0x00, bout=0.
- Backpressure: hold done_ready=0 for 5 cycles in DONE while driving start_valid=1 with new operands -> diff/bout stay constant, start_ready=0, new operands are not captured. Raise done_ready -> IDLE next cycle, then the new operands are accepted.
- Reset mid-op: accept a=0xAA, b=0x55, assert rst_n=0 after 3 BUSY cycles -> outputs immediately take reset values. After release, a=0x10, b=0x01, bin=0 -> diff=0x0F, bout=0.
- WIDTH=4, exhaustive over all a, b, bin (512 cases) with done_ready=1 -> diff = (a-b-bin) mod 16 and bout = (a < b+bin) against a reference model. Issue interval is 6 cycles.
